// File: rtl/segre_store_buffer_fifo.sv
// N-entry circular store buffer between the TL stage and the D-cache.
// Drains the oldest store on a flush chance and forwards data to loads, youngest entry first.
module segre_store_buffer_fifo #(
  parameter  int unsigned NUM_ELEMS = 4,
  parameter  int unsigned ADDR_W    = 32,
  parameter  int unsigned DATA_W    = 32,
  localparam int unsigned PTR_W     = $clog2(NUM_ELEMS)
) (
  input  logic              clk_i,
  input  logic              rsn_i,
  input  logic              req_store_i,
  input  logic              req_load_i,
  input  logic              flush_chance_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        memop_data_type_i,
  output logic              hit_o,
  output logic              miss_o,
  output logic              data_valid_o,
  output logic              trouble_o,
  output logic [DATA_W-1:0] data_load_o,
  output logic              flush_valid_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_flush_o,
  output logic [1:0]        memop_data_type_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [PTR_W:0]    count_o,
  output logic              overflow_o
);

  // Pointers wrap for free only when the depth is a power of two.
  if (NUM_ELEMS < 2 || (NUM_ELEMS & (NUM_ELEMS - 1)) != 0) begin : g_bad_depth
    $error("segre_store_buffer_fifo: NUM_ELEMS must be a power of two >= 2");
  end

  logic [NUM_ELEMS-1:0] valid_q;
  logic [ADDR_W-1:0]    addr_q [NUM_ELEMS];
  logic [DATA_W-1:0]    data_q [NUM_ELEMS];
  logic [1:0]           type_q [NUM_ELEMS];
  logic [PTR_W-1:0]     head_q;
  logic [PTR_W-1:0]     tail_q;
  logic [PTR_W:0]       count_q;
  logic                 overflow_q;

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full  = (count_q == (PTR_W+1)'(NUM_ELEMS));
  assign empty = (count_q == '0);
  // A full buffer still takes a store when the head drains in the same cycle.
  assign pop   = flush_chance_i && !empty;
  assign push  = req_store_i && (!full || pop);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      valid_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= req_store_i && !push;
      if (pop) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_W'(1);
      end
      // When full, head == tail: the push comes last so the new entry stays valid.
      if (push) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage has no reset; the valid bits alone decide whether an entry exists.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= addr_i;
      data_q[tail_q] <= data_i;
      type_q[tail_q] <= memop_data_type_i;
    end
  end

  logic              lk_found;
  logic              lk_hit;
  logic              lk_trouble;
  logic [DATA_W-1:0] lk_data;
  logic [PTR_W-1:0]  scan_idx;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    lk_found   = 1'b0;
    lk_hit     = 1'b0;
    lk_trouble = 1'b0;
    lk_data    = '0;
    scan_idx   = '0;
    // Walk back from the newest entry; the first word-overlap decides the outcome.
    for (int i = 0; i < NUM_ELEMS; i++) begin
      scan_idx = tail_q - PTR_W'(i + 1);
      if (!lk_found && valid_q[scan_idx] &&
          addr_q[scan_idx][ADDR_W-1:2] == addr_i[ADDR_W-1:2]) begin
        lk_found = 1'b1;
        if (addr_q[scan_idx] == addr_i && type_q[scan_idx] == memop_data_type_i) begin
          lk_hit  = 1'b1;
          lk_data = data_q[scan_idx];
        end else begin
          lk_trouble = 1'b1;
        end
      end
    end
  end

  assign hit_o        = req_load_i && lk_hit;
  assign trouble_o    = req_load_i && lk_trouble;
  assign miss_o       = req_load_i && !lk_found;
  assign data_valid_o = hit_o;
  assign data_load_o  = hit_o ? lk_data : '0;

  assign flush_valid_o     = pop;
  assign addr_o            = pop ? addr_q[head_q] : '0;
  assign data_flush_o      = pop ? data_q[head_q] : '0;
  assign memop_data_type_o = pop ? type_q[head_q] : 2'b00;

  assign full_o     = full;
  assign empty_o    = empty;
  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule
